// File: rtl/pcap_stream_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pcap_stream_monitor
//  Purpose  : Sink stage for a data/strb/valid/eop packet stream. Applies
//             pseudo-random backpressure on ready. Checks strobe framing and
//             packet length. Emits one report per packet and keeps
//             saturating statistics counters.
//  Ports    : clk, rst            - clock, async active-high reset
//             data/strb/valid/eop - input beat stream
//             ready               - registered accept (LFSR stall / hold)
//             hold                - forces ready low on the next cycle
//             rpt_*               - per-packet report, valid one cycle
//             pkt_cnt/byte_cnt/err_cnt - saturating statistics
//  Revision : 1.0 - initial release
// ============================================================================
module pcap_stream_monitor #(
  parameter int          AXIS_WIDTH    = 64,
  parameter int          MIN_PKT_BYTES = 14,
  parameter int          MAX_PKT_BYTES = 9600,
  parameter int          BP_NUM        = 0,
  parameter logic [15:0] BP_SEED       = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXIS_WIDTH-1:0]   data,
  input  logic [AXIS_WIDTH/8-1:0] strb,
  input  logic                    valid,
  input  logic                    eop,
  output logic                    ready,
  input  logic                    hold,
  output logic                    rpt_valid,
  output logic [15:0]             rpt_len,
  output logic [15:0]             rpt_beats,
  output logic [31:0]             rpt_gap,
  output logic [3:0]              rpt_err,
  output logic [31:0]             pkt_cnt,
  output logic [47:0]             byte_cnt,
  output logic [15:0]             err_cnt
);

  localparam int                  c_STRB_W   = AXIS_WIDTH / 8;
  localparam logic [c_STRB_W-1:0] c_STRB_ONE = c_STRB_W'(1);
  localparam logic [c_STRB_W-1:0] c_STRB_ALL = '1;
  localparam logic [4:0]          c_BP_NUM   = 5'(BP_NUM);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_lfsr;
  logic        r_ready;
  logic [16:0] r_len;
  logic [15:0] r_beats;
  logic [1:0]  r_err;
  logic [31:0] r_gap_cnt;
  logic [31:0] r_pkt_gap;
  logic        r_rpt_valid;
  logic [15:0] r_rpt_len, r_rpt_beats, r_err_cnt;
  logic [31:0] r_rpt_gap, r_pkt_cnt;
  logic [3:0]  r_rpt_err;
  logic [47:0] r_byte_cnt;

  // Payload is only sampled; it plays no part in framing checks.
  logic w_unused_data;
  assign w_unused_data = ^data;

  logic        w_accept, w_first, w_fire, w_stall, w_lfsr_fb;
  logic        w_strb_bad, w_partial, w_runt, w_giant;
  logic [7:0]  w_beat_bytes;
  logic [16:0] w_len_base, w_len_next;
  logic [17:0] w_len_sum;
  logic [15:0] w_beats_next, w_rpt_len;
  logic [1:0]  w_err_next;
  logic [3:0]  w_rpt_err;
  logic [48:0] w_byte_sum;

  assign w_accept = valid && r_ready;
  assign w_first  = (r_state == ST_IDLE);
  assign w_fire   = w_accept && eop;

  always_comb begin
    w_beat_bytes = '0;
    for (int i = 0; i < c_STRB_W; i++) begin
      w_beat_bytes = w_beat_bytes + 8'(strb[i]);
    end
  end

  // Legal strobe is 2^k-1, k>=1: non-zero and adding one clears every set bit.
  assign w_strb_bad = (strb == '0) || ((strb & (strb + c_STRB_ONE)) != '0);
  assign w_partial  = !eop && (strb != c_STRB_ALL);

  // First beat restarts the accumulators from this beat's own contribution.
  assign w_len_base   = w_first ? 17'd0 : r_len;
  assign w_len_sum    = {1'b0, w_len_base} + 18'(w_beat_bytes);
  assign w_len_next   = w_len_sum[17] ? 17'h1FFFF : w_len_sum[16:0];
  assign w_beats_next = w_first ? 16'd1 : ((r_beats == 16'hFFFF) ? r_beats : r_beats + 16'd1);
  assign w_err_next   = (w_first ? 2'b00 : r_err) | {w_partial, w_strb_bad};

  assign w_runt    = (w_len_next < 17'(MIN_PKT_BYTES));
  assign w_giant   = (w_len_next > 17'(MAX_PKT_BYTES)) || (w_len_next == 17'h1FFFF);
  assign w_rpt_len = w_len_next[16] ? 16'hFFFF : w_len_next[15:0];
  assign w_rpt_err = {w_giant, w_runt, w_err_next};

  assign w_byte_sum = {1'b0, r_byte_cnt} + 49'(w_rpt_len);

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_stall   = ({1'b0, r_lfsr[3:0]} < c_BP_NUM);

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = eop ? ST_IDLE : ST_IN_PKT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr  <= BP_SEED;
      r_ready <= 1'b0;
    end else begin
      r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
      r_ready <= !hold && !w_stall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_beats   <= '0;
      r_err     <= '0;
      r_gap_cnt <= '1;
      r_pkt_gap <= '0;
    end else begin
      if (w_accept) begin
        r_len   <= w_len_next;
        r_beats <= w_beats_next;
        r_err   <= w_err_next;
        if (w_first) begin
          r_pkt_gap <= r_gap_cnt;
        end
      end
      if (w_fire) begin
        r_gap_cnt <= '0;
      end else if (w_first && !w_accept && (r_gap_cnt != '1)) begin
        r_gap_cnt <= r_gap_cnt + 32'd1;
      end
    end
  end

  // Report and statistics share the edge after eop acceptance so both
  // become visible together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpt_valid <= 1'b0;
      r_rpt_len   <= '0;
      r_rpt_beats <= '0;
      r_rpt_gap   <= '0;
      r_rpt_err   <= '0;
      r_pkt_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_rpt_valid <= w_fire;
      if (w_fire) begin
        r_rpt_len   <= w_rpt_len;
        r_rpt_beats <= w_beats_next;
        r_rpt_gap   <= w_first ? r_gap_cnt : r_pkt_gap;
        r_rpt_err   <= w_rpt_err;
        if (r_pkt_cnt != '1) begin
          r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
        r_byte_cnt <= w_byte_sum[48] ? 48'hFFFF_FFFF_FFFF : w_byte_sum[47:0];
        if ((w_rpt_err != 4'd0) && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign ready     = r_ready;
  assign rpt_valid = r_rpt_valid;
  assign rpt_len   = r_rpt_len;
  assign rpt_beats = r_rpt_beats;
  assign rpt_gap   = r_rpt_gap;
  assign rpt_err   = r_rpt_err;
  assign pkt_cnt   = r_pkt_cnt;
  assign byte_cnt  = r_byte_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcap_stream_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pcap_stream_monitor
//  Purpose  : Scoreboard bench for pcap_stream_monitor. One instance runs
//             without backpressure for framing/length/gap/statistics vectors,
//             a second runs with BP_NUM=8 for ordering and ready duty.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pcap_stream_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic        rst, valid, eop, hold;
  logic [63:0] data;
  logic [7:0]  strb;
  logic        ready, rpt_valid;
  logic [15:0] rpt_len, rpt_beats, err_cnt;
  logic [31:0] rpt_gap, pkt_cnt;
  logic [3:0]  rpt_err;
  logic [47:0] byte_cnt;

  // backpressure instance signals
  logic        b_rst, b_valid, b_eop;
  logic        b_hold = 1'b0;
  logic [63:0] b_data;
  logic [7:0]  b_strb;
  logic        b_ready, b_rpt_valid;
  logic [15:0] b_rpt_len, b_rpt_beats, b_err_cnt;
  logic [31:0] b_rpt_gap, b_pkt_cnt;
  logic [3:0]  b_rpt_err;
  logic [47:0] b_byte_cnt;

  pcap_stream_monitor u_dut (
    .clk(clk), .rst(rst), .data(data), .strb(strb), .valid(valid), .eop(eop),
    .ready(ready), .hold(hold), .rpt_valid(rpt_valid), .rpt_len(rpt_len),
    .rpt_beats(rpt_beats), .rpt_gap(rpt_gap), .rpt_err(rpt_err),
    .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .err_cnt(err_cnt)
  );

  pcap_stream_monitor #(.BP_NUM(8)) u_bp (
    .clk(clk), .rst(b_rst), .data(b_data), .strb(b_strb), .valid(b_valid), .eop(b_eop),
    .ready(b_ready), .hold(b_hold), .rpt_valid(b_rpt_valid), .rpt_len(b_rpt_len),
    .rpt_beats(b_rpt_beats), .rpt_gap(b_rpt_gap), .rpt_err(b_rpt_err),
    .pkt_cnt(b_pkt_cnt), .byte_cnt(b_byte_cnt), .err_cnt(b_err_cnt)
  );

  typedef struct {
    longint     len;
    longint     beats;
    longint     gap;
    logic [3:0] err;
    longint     pkt;
    longint     bytes;
    longint     errs;
  } exp_t;

  exp_t   q[$];
  exp_t   q2[$];
  int     tests = 0;
  int     failed = 0;
  int     cyc = 0;
  int     rc[64];
  int     rpt_idx = 0;
  logic   first;
  longint m_pkt, m_bytes, m_errs;
  logic   bp_active = 1'b0;
  logic   bp_done = 1'b0;
  int     bp_cyc = 0;
  int     bp_rdy = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (bp_active) begin
      bp_cyc++;
      if (b_ready) bp_rdy++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (rpt_valid === 1'b1) begin
      if (rpt_idx < 64) rc[rpt_idx] = cyc;
      rpt_idx++;
      if (q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL rpt_unexpected: got report len %0d expected no report", rpt_len);
      end else begin
        e = q.pop_front();
        chk("rpt_len",   64'(rpt_len),   64'(e.len));
        chk("rpt_beats", 64'(rpt_beats), 64'(e.beats));
        chk("rpt_gap",   64'(rpt_gap),   64'(e.gap));
        chk("rpt_err",   64'(rpt_err),   64'(e.err));
        chk("pkt_cnt",   64'(pkt_cnt),   64'(e.pkt));
        chk("byte_cnt",  64'(byte_cnt),  64'(e.bytes));
        chk("err_cnt",   64'(err_cnt),   64'(e.errs));
      end
    end
  end

  always @(negedge clk) begin : mon_bp
    exp_t e;
    if (b_rpt_valid === 1'b1) begin
      if (q2.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL bp_rpt_unexpected: got report len %0d expected no report", b_rpt_len);
      end else begin
        e = q2.pop_front();
        chk("bp_rpt_len",   64'(b_rpt_len),   64'(e.len));
        chk("bp_rpt_beats", 64'(b_rpt_beats), 64'(e.beats));
        chk("bp_rpt_err",   64'(b_rpt_err),   64'(e.err));
      end
    end
  end

  // ---------------- main-instance stimulus helpers ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int len, input int beats, input int gap, input logic [3:0] err);
    exp_t   e;
    longint l;
    l = (len > 65535) ? 65535 : len;
    m_pkt++;
    m_bytes += l;
    if (err != 4'd0) m_errs++;
    e.len   = l;
    e.beats = beats;
    e.gap   = first ? 64'h0000_0000_FFFF_FFFF : gap;
    first   = 1'b0;
    e.err   = err;
    e.pkt   = m_pkt;
    e.bytes = m_bytes;
    e.errs  = m_errs;
    q.push_back(e);
  endtask

  task automatic send_beat(input logic [7:0] s, input logic e);
    logic acc;
    int   n;
    n     = 0;
    data  = {$urandom, $urandom};
    strb  = s;
    eop   = e;
    valid = 1'b1;
    do begin
      acc = ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) begin
      tests++;
      failed++;
      $display("FAIL accept_timeout: ready %0b required 1", ready);
    end
    valid = 1'b0;
    eop   = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int gap);
    int         nb;
    int         rem;
    logic [3:0] err;
    nb  = (len + 7) / 8;
    rem = len % 8;
    err = 4'd0;
    if (len < 14)   err[2] = 1'b1;
    if (len > 9600) err[3] = 1'b1;
    idle_cycles(gap);
    push_exp(len, nb, gap, err);
    for (int i = 0; i < nb - 1; i++) send_beat(8'hFF, 1'b0);
    send_beat((rem == 0) ? 8'hFF : 8'((1 << rem) - 1), 1'b1);
  endtask

  // ---------------- backpressure-instance stimulus ----------------
  task automatic bp_beat(input logic [7:0] s, input logic e);
    logic acc;
    int   n;
    n       = 0;
    b_data  = {$urandom, $urandom};
    b_strb  = s;
    b_eop   = e;
    b_valid = 1'b1;
    do begin
      acc = b_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) begin
      tests++;
      failed++;
      $display("FAIL bp_accept_timeout: ready %0b required 1", b_ready);
    end
    b_valid = 1'b0;
    b_eop   = 1'b0;
  endtask

  initial begin : drv_bp
    exp_t e;
    int   len, nb, rem;
    logic in_range;
    b_rst = 1'b1; b_valid = 1'b0; b_eop = 1'b0; b_strb = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    b_rst     = 1'b0;
    bp_active = 1'b1;
    for (int i = 0; i < 40; i++) begin
      len = 1 + ((i * 53) % 120);
      nb  = (len + 7) / 8;
      rem = len % 8;
      e.len = len; e.beats = nb; e.gap = 0;
      e.err = (len < 14) ? 4'b0100 : 4'b0000;
      e.pkt = 0; e.bytes = 0; e.errs = 0;
      q2.push_back(e);
      for (int j = 0; j < nb - 1; j++) bp_beat(8'hFF, 1'b0);
      bp_beat((rem == 0) ? 8'hFF : 8'((1 << rem) - 1), 1'b1);
    end
    repeat (20) @(posedge clk);
    #1;
    bp_active = 1'b0;
    chk("bp_queue_drained", 64'(q2.size()), 64'd0);
    in_range = (bp_rdy * 100 >= bp_cyc * 30) && (bp_rdy * 100 <= bp_cyc * 70);
    chk("bp_ready_duty_30_70pct", 64'(in_range), 64'd1);
    bp_done = 1'b1;
  end

  // ---------------- main directed sequence ----------------
  initial begin : drv_main
    int n;
    rst = 1'b1; valid = 1'b0; eop = 1'b0; hold = 1'b0; strb = '0; data = '0;
    first = 1'b1; m_pkt = 0; m_bytes = 0; m_errs = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready",     64'(ready),     64'd0);
    chk("reset_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("reset_rpt_len",   64'(rpt_len),   64'd0);
    chk("reset_rpt_gap",   64'(rpt_gap),   64'd0);
    chk("reset_pkt_cnt",   64'(pkt_cnt),   64'd0);
    chk("reset_byte_cnt",  64'(byte_cnt),  64'd0);
    chk("reset_err_cnt",   64'(err_cnt),   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_first_edge", 64'(ready), 64'd1);

    // three 60-byte packets, IFG 6
    send_pkt(60, 0);
    send_pkt(60, 6);
    send_pkt(60, 6);

    // single-beat packets back to back, then a 64-byte packet with no idle
    send_pkt(5, 3);
    send_pkt(8, 0);
    send_pkt(64, 0);
    idle_cycles(2);
    chk("consecutive_rpt_valid", 64'(rc[4] - rc[3]), 64'd1);

    // framing errors
    push_exp(3, 1, 2, 4'b0101);
    send_beat(8'h0B, 1'b1);
    idle_cycles(2);
    push_exp(23, 3, 2, 4'b0010);
    send_beat(8'hFF, 1'b0);
    send_beat(8'h7F, 1'b0);
    send_beat(8'hFF, 1'b1);

    // length boundaries
    send_pkt(10, 1);
    send_pkt(9601, 1);
    send_pkt(70000, 1);

    // hold drops ready exactly one cycle later
    hold = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_ready_low", 64'(ready), 64'd0);
    hold = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_release_ready", 64'(ready), 64'd1);

    // reset during beat 4 of a 200-byte packet
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    strb  = 8'hFF;
    valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    valid = 1'b0;
    idle_cycles(2);
    chk("midrst_pkt_cnt",   64'(pkt_cnt),   64'd0);
    chk("midrst_byte_cnt",  64'(byte_cnt),  64'd0);
    chk("midrst_err_cnt",   64'(err_cnt),   64'd0);
    chk("midrst_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("midrst_ready",     64'(ready),     64'd0);
    rst = 1'b0;
    first = 1'b1; m_pkt = 0; m_bytes = 0; m_errs = 0;
    send_pkt(200, 1);

    idle_cycles(4);
    chk("queue_drained", 64'(q.size()), 64'd0);

    n = 0;
    while (!bp_done && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("bp_sequence_done", 64'(bp_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
